// File: rtl/freq_meter_mc_pkg.sv
// Shared types and helpers for the multi-channel gated frequency meter.
// Holds the FSM state encoding, the gate_sel encodings and gate-counter sizing.
package freq_meter_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GATE_SEL_0 = 2'd0,
    GATE_SEL_1 = 2'd1,
    GATE_SEL_2 = 2'd2,
    GATE_SEL_3 = 2'd3
  } gate_sel_e;

  // The gate counter is sized from the longest selectable window.
  function automatic int maxGate(input int g0, input int g1, input int g2, input int g3);
    int m;
    m = g0;
    if (g1 > m) m = g1;
    if (g2 > m) m = g2;
    if (g3 > m) m = g3;
    return m;
  endfunction

endpackage

// File: rtl/freq_meter_mc_if.sv
// Measurement bus between the frequency meter and its stimulus/readout side.
// Master drives the measured signals and controls; slave (the meter) returns results.
interface freq_meter_mc_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32
);

  logic [CH_NUM-1:0]       sig_in;
  logic                    enable;
  logic [1:0]              gate_sel;
  logic [CH_NUM*CNT_W-1:0] freq_cnt;
  logic [CH_NUM-1:0]       ovf;
  logic                    meas_valid;
  logic                    busy;

  modport master (
    output sig_in, enable, gate_sel,
    input  freq_cnt, ovf, meas_valid, busy
  );

  modport slave (
    input  sig_in, enable, gate_sel,
    output freq_cnt, ovf, meas_valid, busy
  );

endinterface

// File: rtl/freq_meter_mc_edge_sync_detect.sv
// Synchronises one asynchronous input and emits a registered one-cycle rise pulse,
// SYNC_STAGES+1 cycles after the input edge.
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  if (SYNC_STAGES < 2) begin : gBadStages
    $error("edge_sync_detect: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Registering the pulse keeps the count enable free of synchroniser-to-counter logic depth.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency counter: counts synchronised rising edges per channel
// over a selectable gate window and latches all channels together with a valid strobe.
module freq_meter_mc
  import freq_meter_mc_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int GATE0       = 100_000_000,
  parameter int GATE1       = 10_000_000,
  parameter int GATE2       = 1_000_000,
  parameter int GATE3       = 200_000_000
) (
  input logic             sys_clk,
  input logic             rst_n,
  freq_meter_mc_if.slave  bus
);

  localparam int GATE_MAX = maxGate(GATE0, GATE1, GATE2, GATE3);
  localparam int GATE_W   = $clog2(GATE_MAX);

  if (GATE0 < 2 || GATE1 < 2 || GATE2 < 2 || GATE3 < 2) begin : gBadGate
    $error("freq_meter_mc: every GATEx must be at least 2");
  end

  if (CH_NUM < 1 || CH_NUM > 16) begin : gBadChNum
    $error("freq_meter_mc: CH_NUM must be within 1..16");
  end

  state_t              state_q, state_d;
  logic [GATE_W-1:0]   gateCnt_q, gateCnt_d;
  logic [GATE_W-1:0]   gateLast_q, gateLast_d;
  logic                measValid_q;
  logic                clearCnt;
  logic                countEn;
  logic                doLatch;
  logic [CH_NUM-1:0]   rise;
  logic [CH_NUM*CNT_W-1:0] freqCntAll;
  logic [CH_NUM-1:0]   ovfAll;

  // The window length is stored as its last count value so the end test is a plain compare.
  function automatic logic [GATE_W-1:0] gateLastFor(input logic [1:0] sel);
    case (gate_sel_e'(sel))
      GATE_SEL_0: return GATE_W'(GATE0 - 1);
      GATE_SEL_1: return GATE_W'(GATE1 - 1);
      GATE_SEL_2: return GATE_W'(GATE2 - 1);
      GATE_SEL_3: return GATE_W'(GATE3 - 1);
      default:    return GATE_W'(GATE0 - 1);
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gateCnt_q   <= '0;
      gateLast_q  <= '0;
      measValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gateCnt_q   <= gateCnt_d;
      gateLast_q  <= gateLast_d;
      measValid_q <= doLatch;
    end
  end

  // LATCH always lasts one cycle, so the strobe can never fire on consecutive cycles.
  always_comb begin
    state_d    = state_q;
    gateCnt_d  = gateCnt_q;
    gateLast_d = gateLast_q;
    clearCnt   = 1'b0;
    countEn    = 1'b0;
    doLatch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          gateLast_d = gateLastFor(bus.gate_sel);
          gateCnt_d  = '0;
          clearCnt   = 1'b1;
          state_d    = GATE;
        end
      end
      GATE: begin
        if (!bus.enable) begin
          gateCnt_d = '0;
          clearCnt  = 1'b1;
          state_d   = IDLE;
        end else begin
          countEn = 1'b1;
          if (gateCnt_q == gateLast_q) begin
            gateCnt_d = '0;
            state_d   = LATCH;
          end else begin
            gateCnt_d = gateCnt_q + GATE_W'(1);
          end
        end
      end
      LATCH: begin
        doLatch   = 1'b1;
        clearCnt  = 1'b1;
        gateCnt_d = '0;
        if (bus.enable) begin
          gateLast_d = gateLastFor(bus.gate_sel);
          state_d    = GATE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : gCh
    logic [CNT_W-1:0] cnt_q;
    logic             ovfFlag_q;
    logic [CNT_W-1:0] freqCnt_q;
    logic             ovfOut_q;

    edge_sync_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) uSync (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .sig_i  (bus.sig_in[i]),
      .rise_o (rise[i])
    );

    // At LATCH the outputs capture the old count while the same edge clears it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        ovfFlag_q <= 1'b0;
        freqCnt_q <= '0;
        ovfOut_q  <= 1'b0;
      end else begin
        if (clearCnt) begin
          cnt_q     <= '0;
          ovfFlag_q <= 1'b0;
        end else if (countEn && rise[i]) begin
          if (&cnt_q) begin
            ovfFlag_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        if (doLatch) begin
          freqCnt_q <= cnt_q;
          ovfOut_q  <= ovfFlag_q;
        end
      end
    end

    assign freqCntAll[i*CNT_W +: CNT_W] = freqCnt_q;
    assign ovfAll[i]                    = ovfOut_q;
  end

  assign bus.freq_cnt   = freqCntAll;
  assign bus.ovf        = ovfAll;
  assign bus.meas_valid = measValid_q;
  assign bus.busy       = (state_q == GATE) || (state_q == LATCH);

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc: expected window results are queued as stimulus is
// applied and popped by a monitor each time meas_valid fires.
module tb_freq_meter_mc;

  localparam int CH_NUM = 2;
  localparam int CNT_W  = 4;
  localparam int G0     = 100;
  localparam int G1     = 20;
  localparam int G2     = 4;
  localparam int G3     = 8;

  typedef struct packed {
    logic [CH_NUM*CNT_W-1:0] freqCnt;
    logic [CH_NUM-1:0]       ovf;
  } expect_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  int checks       = 0;
  int errors       = 0;
  int cyc          = 0;
  int validCnt     = 0;
  int lastValidCyc = -1;
  int prevValidCyc = -1;
  int startCyc     = 0;
  int validSnap    = 0;

  expect_t           sb[$];
  expect_t           expNow;
  logic              prevMv  = 1'b0;
  logic [CH_NUM-1:0] togMask = '0;
  int                togHalf = 5;
  int                togCnt  = 0;

  freq_meter_mc_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) bus ();

  freq_meter_mc #(
    .CH_NUM     (CH_NUM),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .GATE0      (G0),
    .GATE1      (G1),
    .GATE2      (G2),
    .GATE3      (G3)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic expect_t mkExp(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                                    input logic [CH_NUM-1:0] o);
    expect_t e;
    e.freqCnt = {c1, c0};
    e.ovf     = o;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel);
    bus.enable   = en;
    bus.gate_sel = sel;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic tickUntil(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic waitValid(input string tag, input int maxCyc);
    int start;
    int n;
    start = validCnt;
    n = 0;
    while (validCnt == start && n < maxCyc) begin
      tick(1);
      n++;
    end
    checks++;
    assert (validCnt != start) else begin
      errors++;
      $error("[TB] FAIL %s timeout observed=no_valid expected=valid within %0d cycles", tag, maxCyc);
    end
  endtask

  // Free-running toggler for periodic channel stimulus; runs after the main process each cycle.
  initial begin : toggler
    forever begin
      @(posedge sys_clk);
      #2;
      if (togMask != '0) begin
        togCnt++;
        if (togCnt >= togHalf) begin
          togCnt     = 0;
          bus.sig_in = bus.sig_in ^ togMask;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      if (bus.meas_valid === 1'b1) begin
        validCnt++;
        prevValidCyc = lastValidCyc;
        lastValidCyc = cyc;
        checkOutput($sformatf("w%0d_valid_not_back_to_back", validCnt), 32'(prevMv), 32'd0);
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("[TB] FAIL w%0d_unexpected_valid observed=valid expected=none", validCnt);
        end
        if (sb.size() != 0) begin
          expNow = sb.pop_front();
          checkOutput($sformatf("w%0d_freq_cnt", validCnt), 32'(bus.freq_cnt), 32'(expNow.freqCnt));
          checkOutput($sformatf("w%0d_ovf", validCnt), 32'(bus.ovf), 32'(expNow.ovf));
        end
      end
      prevMv = bus.meas_valid;
    end
  end

  initial begin : stimulus
    bus.sig_in = '0;
    applyStimulus(1'b0, 2'd0);
    rst_n = 1'b0;
    tick(3);
    checkOutput("rst_freq_cnt", 32'(bus.freq_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick(5);

    $display("[TB] ch0 period 10, ch1 idle, gate 100");
    togHalf = 5;
    togMask = 2'b01;
    tick(30);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    repeat (3) sb.push_back(mkExp(4'd10, 4'd0, 2'b00));
    startCyc = cyc;
    applyStimulus(1'b1, 2'd0);
    waitValid("first_window", 150);
    checkOutput("first_valid_latency", 32'(lastValidCyc - startCyc), 32'd102);
    waitValid("second_window", 150);
    checkOutput("spacing_gate0", 32'(lastValidCyc - prevValidCyc), 32'd101);
    waitValid("third_window", 150);

    $display("[TB] abort at gate_cnt 50");
    tickUntil(lastValidCyc + 50);
    checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
    validSnap = validCnt;
    applyStimulus(1'b0, 2'd0);
    tick(2);
    checkOutput("abort_busy_after", 32'(bus.busy), 32'd0);
    tick(150);
    checkOutput("abort_no_valid", 32'(validCnt), 32'(validSnap));
    checkOutput("abort_freq_cnt_held", 32'(bus.freq_cnt), 32'h0A);
    checkOutput("abort_ovf_held", 32'(bus.ovf), 32'd0);

    $display("[TB] ch0 saturation then idle window");
    togHalf = 1;
    tick(10);
    sb.push_back(mkExp(4'd15, 4'd0, 2'b01));
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    applyStimulus(1'b1, 2'd0);
    tick(60);
    togMask       = '0;
    bus.sig_in[0] = 1'b0;
    waitValid("saturate_window", 150);
    waitValid("clear_window", 150);

    $display("[TB] gate_sel switch mid-window");
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    sb.push_back(mkExp(4'd1, 4'd0, 2'b00));
    tickUntil(lastValidCyc + 30);
    applyStimulus(1'b1, 2'd1);
    waitValid("sel_window_old", 150);
    checkOutput("spacing_before_switch", 32'(lastValidCyc - prevValidCyc), 32'd101);
    waitValid("sel_window_new", 40);
    checkOutput("spacing_after_switch", 32'(lastValidCyc - prevValidCyc), 32'd21);

    $display("[TB] edge pulse on LATCH cycle, then on last gate cycle");
    tickUntil(lastValidCyc + 17);
    bus.sig_in[0] = 1'b1;
    waitValid("latch_edge_window", 40);
    checkOutput("spacing_gate1", 32'(lastValidCyc - prevValidCyc), 32'd21);
    tickUntil(lastValidCyc + 2);
    bus.sig_in[0] = 1'b0;
    waitValid("after_latch_edge_window", 40);
    tickUntil(lastValidCyc + 16);
    bus.sig_in[0] = 1'b1;
    waitValid("last_gate_edge_window", 40);

    $display("[TB] asynchronous reset mid-gate");
    tick(5);
    bus.sig_in = 2'b10;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_freq_cnt", 32'(bus.freq_cnt), 32'd0);
    checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("midrst_meas_valid", 32'(bus.meas_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    bus.sig_in = '0;
    applyStimulus(1'b1, 2'd0);
    tick(3);
    rst_n    = 1'b1;
    startCyc = cyc;
    sb.push_back(mkExp(4'd0, 4'd0, 2'b00));
    waitValid("post_reset_window", 150);
    checkOutput("post_reset_latency", 32'(lastValidCyc - startCyc), 32'd102);

    $display("[TB] simultaneous edges on both channels");
    applyStimulus(1'b0, 2'd0);
    tick(3);
    togHalf = 5;
    togCnt  = 0;
    togMask = 2'b11;
    tick(30);
    sb.push_back(mkExp(4'd10, 4'd10, 2'b00));
    applyStimulus(1'b1, 2'd0);
    waitValid("simultaneous_window", 150);
    applyStimulus(1'b0, 2'd0);
    togMask = '0;
    tick(5);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
